// File: rtl/rca_4bit_adder_pkg.sv
// Shared width constant and word type for the registered ripple-carry adder.
package rca_4bit_adder_pkg;

    localparam int ADDER_W = 4;

    typedef logic [ADDER_W-1:0] adder_word_t;

endpackage : rca_4bit_adder_pkg

// File: rtl/rca_4bit_adder_full_adder.sv
// Single-bit full-adder cell; purely combinational, chained by the top level.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic half_sum;

    assign half_sum = a ^ b;
    assign s        = half_sum ^ ci;
    assign co       = (a & b) | (ci & half_sum);

endmodule : full_adder

// File: rtl/rca_4bit_adder.sv
// Registered ripple-carry adder: {cout, s} = a + b + cin one cycle later,
// with signed overflow taken from the carries around the MSB cell.
module rca_4bit_adder
    import rca_4bit_adder_pkg::*;
#(
    parameter int WIDTH = ADDER_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;
    logic             ovf_next;

    assign carry[0] = cin;

    // Pure ripple: each cell's carry-out feeds the next cell's carry-in.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
        full_adder u_fa (
            .a  (a[gi]),
            .b  (b[gi]),
            .ci (carry[gi]),
            .s  (sum[gi]),
            .co (carry[gi+1])
        );
    end

    assign ovf_next = carry[WIDTH] ^ carry[WIDTH-1];

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values;
    // the reset is synchronous, so it only takes effect on a rising clk edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s    <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            s    <= sum;
            cout <= carry[WIDTH];
            ovf  <= ovf_next;
        end
    end

endmodule : rca_4bit_adder

// File: tb/tb_rca_4bit_adder.sv
// Scoreboard bench: driver pushes expected results, negedge monitor pops and compares.
module tb_rca_4bit_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] s;
    logic       cout;
    logic       ovf;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [5:0] result;   // {cout, s, ovf}
        string      name;
    } exp_t;

    exp_t exp_q[$];

    rca_4bit_adder #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Reference: unsigned sum for {cout,s}, signed-range test for overflow.
    function automatic logic [5:0] model(input int av, input int bv, input int cv);
        int u;
        int sa;
        int sb;
        int sv;
        logic [3:0] sm;
        logic co;
        logic ov;
        u  = av + bv + cv;
        sm = 4'(u % 16);
        co = (u >= 16);
        sa = (av >= 8) ? av - 16 : av;
        sb = (bv >= 8) ? bv - 16 : bv;
        sv = sa + sb + cv;
        ov = (sv > 7) || (sv < -8);
        return {co, sm, ov};
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got cout=%0b s=%0d ovf=%0b, expected cout=%0b s=%0d ovf=%0b",
                     name, act[5], act[4:1], act[0], req[5], req[4:1], req[0]);
        end
    endtask

    // Drive one cycle of inputs, then record what the edge should produce.
    task automatic step(input string name, input bit rst, input int av, input int bv, input int cv);
        exp_t e;
        rst_n = ~rst;
        a     = 4'(av);
        b     = 4'(bv);
        cin   = cv[0];
        @(posedge clk);
        e.result = rst ? 6'd0 : model(av, bv, cv);
        e.name   = name;
        exp_q.push_back(e);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.name, {cout, s, ovf}, e.result);
            end
        end
    end

    initial begin : stimulus
        int wait_cycles;
        #1;
        // Reset held two edges with non-zero inputs, then released.
        step("reset_0", 1'b1, 9, 7, 1);
        step("reset_1", 1'b1, 9, 7, 1);
        step("post_reset", 1'b0, 9, 7, 1);
        step("basic_3p5", 1'b0, 3, 5, 0);
        step("max_all", 1'b0, 15, 15, 1);
        step("wrap_15p1", 1'b0, 15, 1, 0);
        step("ripple", 1'b0, 15, 0, 1);
        step("zeros", 1'b0, 0, 0, 0);
        step("cin_only", 1'b0, 0, 0, 1);
        step("b2b_0", 1'b0, 1, 2, 0);
        step("b2b_1", 1'b0, 8, 8, 0);
        step("b2b_2", 1'b0, 7, 0, 1);
        // Random stream with a mid-sequence reset.
        for (int i = 0; i < 40; i++) begin
            if (i == 20)
                step("rand_reset", 1'b1, int'($urandom_range(15)), int'($urandom_range(15)),
                     int'($urandom_range(1)));
            else
                step("random", 1'b0, int'($urandom_range(15)), int'($urandom_range(15)),
                     int'($urandom_range(1)));
        end
        // Drain the scoreboard with a bounded wait.
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expected results never checked, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_rca_4bit_adder
